// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous data-memory port
// between NUM_CORES cores. Each access is a short IDLE -> ISSUE (-> RESP)
// walk; reads return data one cycle after issue. New grants are withheld
// while the host loader owns the memory (load_active).
// Optional build macro DMEM_ARB_STATS_EN adds a saturating stall counter
// output (stall_count).
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 12,
    parameter int DW        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_active,
    input  logic [NUM_CORES-1:0]    core_req,
    input  logic [NUM_CORES-1:0]    core_we,
    input  logic [NUM_CORES*AW-1:0] core_addr,
    input  logic [NUM_CORES*DW-1:0] core_wdata,
    output logic [NUM_CORES-1:0]    core_gnt,
    output logic [NUM_CORES-1:0]    core_rvalid,
    output logic [DW-1:0]           core_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]             stall_count
`endif
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   win_reg, win_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;

    logic            win_found;
    logic [PW-1:0]   win_sel;
    logic [PW-1:0]   scan_cand;
    int              scan_idx;

    // Round-robin scan starting at ptr; walking offsets from high to low
    // leaves the requester closest to ptr as the winner.
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        scan_idx  = 0;
        scan_cand = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            scan_idx  = (int'(ptr_reg) + k) % NUM_CORES;
            scan_cand = PW'(scan_idx);
            if (core_req[scan_cand]) begin
                win_found = 1'b1;
                win_sel   = scan_cand;
            end
        end
    end

    // Next-state logic; the winner's request is captured on leaving IDLE so
    // the memory sees stable values even after the core drops its request.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (!load_active && win_found) begin
                    state_next = ISSUE;
                    win_next   = win_sel;
                    we_next    = core_we[win_sel];
                    addr_next  = core_addr[win_sel*AW +: AW];
                    wdata_next = core_wdata[win_sel*DW +: DW];
                    ptr_next   = (win_sel == PW'(NUM_CORES - 1)) ? '0
                                                                : win_sel + PW'(1);
                end
            end
            ISSUE:   state_next = we_reg ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and captured-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            win_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Memory side: address/data simply hold the last captured request.
    assign mem_en     = (state_reg == ISSUE);
    assign mem_we     = (state_reg == ISSUE) && we_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign core_rdata = (state_reg == RESP) ? mem_rdata : '0;
    assign busy       = (state_reg != IDLE);

    // Per-core one-hot grant and read-valid pulses.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        assign core_gnt[gi]    = (state_reg == ISSUE) && (win_reg == PW'(gi));
        assign core_rvalid[gi] = (state_reg == RESP)  && (win_reg == PW'(gi));
    end

`ifdef DMEM_ARB_STATS_EN
    // Count cycles in which some core is requesting without being granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (|(core_req & ~core_gnt) && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, hand-written corner sequences and a
// randomized run checked against a schedule-based reference model.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int NR = 1500;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_active;
    logic [N-1:0]    core_req, core_we;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_gnt, core_rvalid;
    logic [DW-1:0]   core_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            busy;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]     stall_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_CORES(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .load_active(load_active),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    // Synchronous RAM behind the arbiter, preloaded with addr ^ 0x5A5A.
    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a) ^ 16'h5A5A;
    endfunction

    logic [DW-1:0] ram [0:4095];
    logic [DW-1:0] ram_rdata;
    logic          ram_ready = 1'b0;
    assign mem_rdata = ram_rdata;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        core_req[i]             = 1'b1;
        core_we[i]              = we;
        core_addr[i*AW +: AW]   = a;
        core_wdata[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        load_active = 1'b0;
        core_req    = '0;
        step();
        step();
        chk("rst_gnt",    32'(core_gnt),    0);
        chk("rst_rvalid", 32'(core_rvalid), 0);
        chk("rst_mem_en", 32'(mem_en),      0);
        chk("rst_mem_we", 32'(mem_we),      0);
        chk("rst_addr",   32'(mem_addr),    0);
        chk("rst_wdata",  32'(mem_wdata),   0);
        chk("rst_rdata",  32'(core_rdata),  0);
        chk("rst_busy",   32'(busy),        0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Run n cycles; each core drops its request the cycle after its grant.
    logic [N-1:0] got_g [0:15];
    task automatic auto_run(int n);
        logic [N-1:0] prev;
        prev = '0;
        for (int k = 1; k <= n; k++) begin
            step();
            core_req = core_req & ~prev;
            prev     = core_gnt;
            got_g[k] = core_gnt;
        end
    endtask

    typedef struct {
        int            core;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [N-1:0]  exp_gnt;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t tbl [8];

    // Reference model state for the random run.
    logic [N-1:0]  e_gnt   [0:NR+3];
    logic [N-1:0]  e_rv    [0:NR+3];
    logic          e_en    [0:NR+3];
    logic          e_we    [0:NR+3];
    logic [AW-1:0] e_addr  [0:NR+3];
    logic [DW-1:0] e_wd    [0:NR+3];
    logic [DW-1:0] e_rd    [0:NR+3];
    logic [DW-1:0] shadow  [int];

    function automatic logic [DW-1:0] sh_read(int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    initial begin
        int mptr, free_at, w, a;
        logic [N-1:0] prev_g, dropped;

        tbl[0] = '{2, 1'b1, 12'h010, 16'h1234, 4'b0100, 16'h0000};
        tbl[1] = '{2, 1'b0, 12'h010, 16'h0000, 4'b0100, 16'h1234};
        tbl[2] = '{0, 1'b1, 12'hFFF, 16'hBEEF, 4'b0001, 16'h0000};
        tbl[3] = '{3, 1'b0, 12'hFFF, 16'h0000, 4'b1000, 16'hBEEF};
        tbl[4] = '{1, 1'b0, 12'h000, 16'h0000, 4'b0010, 16'h5A5A};
        tbl[5] = '{1, 1'b1, 12'h7A5, 16'h0000, 4'b0010, 16'h0000};
        tbl[6] = '{0, 1'b0, 12'h7A5, 16'h0000, 4'b0001, 16'h0000};
        tbl[7] = '{3, 1'b0, 12'h123, 16'h0000, 4'b1000, 16'h5B79};

        rst_n = 1'b0; load_active = 1'b0;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        do_reset();

        // Table-driven isolated accesses.
        for (int i = 0; i < 8; i++) begin
            set_core(tbl[i].core, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            step();
            chk("tbl_gnt",    32'(core_gnt), 32'(tbl[i].exp_gnt));
            chk("tbl_mem_en", 32'(mem_en),   1);
            chk("tbl_addr",   32'(mem_addr), 32'(tbl[i].addr));
            chk("tbl_we",     32'(mem_we),   32'(tbl[i].we));
            if (tbl[i].we) chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].wdata));
            step();
            core_req = '0;
            if (!tbl[i].we) begin
                chk("tbl_rvalid", 32'(core_rvalid), 32'(tbl[i].exp_gnt));
                chk("tbl_rdata",  32'(core_rdata),  32'(tbl[i].exp_rdata));
                step();
            end
            chk("tbl_idle_busy", 32'(busy), 0);
            $display("vec %0d: core %0d we=%0d addr=%03h wdata=%04h rdata=%04h", i,
                     tbl[i].core, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
        end

        // All four cores write at once right after reset.
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 12'(12'h020 + i), 16'(16'h00A0 + i));
        auto_run(9);
        for (int k = 1; k <= 9; k++)
            chk("all4_gnt", 32'(got_g[k]), (k % 2 == 1 && k <= 7) ? (1 << ((k - 1) / 2)) : 0);
        step();
        for (int i = 0; i < N; i++) chk("all4_ram", 32'(ram[12'h020 + i]), 32'(16'h00A0 + i));
        $display("seq all4: grants checked at offsets 1,3,5,7");

        // Wrap: move ptr to 3, then cores 0 and 3 compete.
        set_core(2, 1'b1, 12'h030, 16'h0002);
        auto_run(3);
        chk("wrap_setup_gnt", 32'(got_g[1]), 32'b0100);
        set_core(0, 1'b1, 12'h031, 16'h0010);
        set_core(3, 1'b1, 12'h032, 16'h0013);
        auto_run(5);
        chk("wrap_first",  32'(got_g[1]), 32'b1000);
        chk("wrap_second", 32'(got_g[3]), 32'b0001);
        set_core(0, 1'b1, 12'h033, 16'h0020);
        set_core(1, 1'b1, 12'h034, 16'h0021);
        auto_run(6);
        chk("wrap_ptr1_first",  32'(got_g[1]), 32'b0010);
        chk("wrap_ptr1_second", 32'(got_g[3]), 32'b0001);
        $display("seq wrap: core3 then core0, ptr ends at 1");

        // Loader owns memory: no grant, no strobe.
        load_active = 1'b1;
        set_core(1, 1'b0, 12'h020, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("load_gnt",    32'(core_gnt), 0);
            chk("load_mem_en", 32'(mem_en),   0);
        end
        load_active = 1'b0;
        step();
        chk("load_release_gnt", 32'(core_gnt), 32'b0010);
        step();
        core_req = '0;
        chk("load_release_rvalid", 32'(core_rvalid), 32'b0010);
        chk("load_release_rdata",  32'(core_rdata),  32'h00A0);
        step();
        $display("seq load: grant held off for 10 cycles, then issued");

        // Reset during RESP of a core-0 read.
        set_core(0, 1'b0, 12'h021, 16'h0000);
        step();
        chk("rstmid_gnt", 32'(core_gnt), 32'b0001);
        step();
        core_req = '0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rvalid", 32'(core_rvalid), 0);
        chk("rstmid_busy",   32'(busy),        0);
        chk("rstmid_rdata",  32'(core_rdata),  0);
        chk("rstmid_mem_en", 32'(mem_en),      0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_core(0, 1'b0, 12'h022, 16'h0000);
        set_core(1, 1'b0, 12'h023, 16'h0000);
        auto_run(6);
        chk("rstmid_ptr0_first",  32'(got_g[1]), 32'b0001);
        chk("rstmid_ptr0_second", 32'(got_g[4]), 32'b0010);
        $display("seq reset-mid-read: outputs cleared, ptr back to 0");

`ifdef DMEM_ARB_STATS_EN
        do_reset();
        chk("stats_reset", stall_count, 0);
        set_core(0, 1'b1, 12'h830, 16'h0001);
        set_core(1, 1'b1, 12'h831, 16'h0002);
        auto_run(3);
        chk("stats_gnt2",  32'(got_g[3]), 32'b0010);
        chk("stats_count", stall_count, 3);
        auto_run(2);
        $display("seq stats: stall_count at second grant checked");
`endif

        // Randomized run against the schedule model.
        do_reset();
        for (int c = 0; c <= NR + 3; c++) begin
            e_gnt[c] = '0; e_rv[c] = '0; e_en[c] = 1'b0; e_we[c] = 1'b0;
            e_addr[c] = '0; e_wd[c] = '0; e_rd[c] = '0;
        end
        mptr = 0; free_at = 0; prev_g = '0;
        for (int rc = 0; rc < NR; rc++) begin
            if (rc > 0) begin
                chk("rnd_gnt",    32'(core_gnt),    32'(e_gnt[rc]));
                chk("rnd_rvalid", 32'(core_rvalid), 32'(e_rv[rc]));
                chk("rnd_mem_en", 32'(mem_en),      32'(e_en[rc]));
                chk("rnd_busy",   32'(busy),        32'((e_gnt[rc] != 0) || (e_rv[rc] != 0)));
                if (e_en[rc]) begin
                    chk("rnd_addr", 32'(mem_addr), 32'(e_addr[rc]));
                    chk("rnd_we",   32'(mem_we),   32'(e_we[rc]));
                    if (e_we[rc]) chk("rnd_wdata", 32'(mem_wdata), 32'(e_wd[rc]));
                end
                if (e_rv[rc] != 0) chk("rnd_rdata", 32'(core_rdata), 32'(e_rd[rc]));
            end
            dropped  = core_req & prev_g;
            core_req = core_req & ~prev_g;
            prev_g   = core_gnt;
            for (int i = 0; i < N; i++)
                if (!core_req[i] && !dropped[i] && $urandom_range(0, 3) == 0)
                    set_core(i, 1'($urandom_range(0, 1)), 12'(12'h800 + $urandom_range(0, 15)),
                             16'($urandom));
            load_active = ($urandom_range(0, 15) < 3);
            if (rc >= free_at && !load_active && core_req != 0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && core_req[(mptr + k) % N]) w = (mptr + k) % N;
                a = int'(core_addr[w*AW +: AW]);
                e_gnt[rc+1]  = N'(1 << w);
                e_en[rc+1]   = 1'b1;
                e_we[rc+1]   = core_we[w];
                e_addr[rc+1] = AW'(a);
                e_wd[rc+1]   = core_wdata[w*DW +: DW];
                if (core_we[w]) begin
                    shadow[a] = core_wdata[w*DW +: DW];
                    free_at   = rc + 2;
                end else begin
                    e_rv[rc+2] = N'(1 << w);
                    e_rd[rc+2] = sh_read(a);
                    free_at    = rc + 3;
                end
                mptr = (w + 1) % N;
            end
            step();
        end
        core_req = '0;
        load_active = 1'b0;
        step();
        step();
        step();
        $display("random run: %0d cycles", NR);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
